pipe_ctrl: RTL

- Central stall/flush controller for the 5-stage MIPS32 pipeline.
- Collects hazard requests from ID (load-use), EX (multi-cycle ops: MADD/MSUB, DIV) and MEM (slow memory), plus exception requests.
- Produces the per-stage stall vector that freezes the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and a flush with redirect PC.
- Owns the EX multi-cycle sequencer: counter and FSM that hold ID/EX stable for exactly the number of cycles an EX operation needs, plus a stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 43 ++++
 rtl/pipe_ctrl_if.sv | 46 ++++
 rtl/pipe_ctrl_mc_seq.sv | 105 ++++++++++
 rtl/pipe_ctrl.sv | 71 +++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared constants for the MIPS32 pipeline stall/flush controller.
//   - reset level and zero word
//   - default widths for the multi-cycle counter and perf counter
//   - stall vector encodings (bit0 PC .. bit5 WB, 1 = hold)
//   - EX multi-cycle sequencer state encodings
//   - stall_select(): stall priority below the exception level
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  localparam int CNT_W_DEFAULT  = 6;
  localparam int PERF_W_DEFAULT = 32;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [1:0] MC_IDLE = 2'd0;
  localparam logic [1:0] MC_BUSY = 2'd1;
  localparam logic [1:0] MC_HOLD = 2'd2;

  // Deeper stages win: a MEM wait freezes everything upstream of it, so it
  // dominates an EX hold, which in turn dominates an ID load-use bubble.
  function automatic logic [5:0] stall_select(input logic mem_req,
                                              input logic ex_hold,
                                              input logic id_req);
    logic [5:0] sel;
    sel = STALL_NONE;
    if (mem_req)
      sel = STALL_MEM;
    else if (ex_hold)
      sel = STALL_EX;
    else if (id_req)
      sel = STALL_ID;
    return sel;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle of hazard requests into, and stall/flush controls out of, the
// pipeline controller.
//   master : pipeline side; drives requests, observes controls
//   slave  : pipe_ctrl side; observes requests, drives controls
// Requests : stallreq_id, stallreq_mem, ex_mc_start, ex_mc_cycles,
//            exc_req, exc_pc
// Controls : stall[5:0], flush, new_pc, ex_mc_busy, ex_mc_done,
//            ex_mc_abort, perf_stall_cnt
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
);

  logic              stallreq_id;
  logic              stallreq_mem;
  logic              ex_mc_start;
  logic [CNT_W-1:0]  ex_mc_cycles;
  logic              exc_req;
  logic [31:0]       exc_pc;

  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              ex_mc_busy;
  logic              ex_mc_done;
  logic              ex_mc_abort;
  logic [PERF_W-1:0] perf_stall_cnt;

  modport master (
    output stallreq_id, stallreq_mem, ex_mc_start, ex_mc_cycles,
           exc_req, exc_pc,
    input  stall, flush, new_pc, ex_mc_busy, ex_mc_done, ex_mc_abort,
           perf_stall_cnt
  );

  modport slave (
    input  stallreq_id, stallreq_mem, ex_mc_start, ex_mc_cycles,
           exc_req, exc_pc,
    output stall, flush, new_pc, ex_mc_busy, ex_mc_done, ex_mc_abort,
           perf_stall_cnt
  );

endinterface

// File: rtl/pipe_ctrl_mc_seq.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_mc_seq
// EX multi-cycle sequencer: keeps ID/EX frozen for exactly the cycles an
// EX operation (MADD/MSUB, DIV) needs and flags when its result is valid.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         EX begins a multi-cycle op this cycle
//   cycles        total EX occupancy N of that op
//   exc_req       exception in MEM; kills an op in flight
//   stallreq_mem  MEM wait; delays consumption of a finished result
//   ex_hold       request to freeze PC..EX this cycle
//   done          multi-cycle result valid this cycle
//   abort         op in flight killed by the exception this cycle
//   busy          sequencer not idle
// ---------------------------------------------------------------------------
module pipe_ctrl_mc_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cycles,
  input  logic             exc_req,
  input  logic             stallreq_mem,
  output logic             ex_hold,
  output logic             done,
  output logic             abort,
  output logic             busy
);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // The start cycle itself is the first EX cycle and the cnt==0 cycle is the
  // last, so loading N-2 yields N-1 held cycles followed by one done cycle.
  // In HOLD the result is already computed; EX is only kept frozen while MEM
  // still waits, so on the exit cycle the pipeline advances and consumes it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ex_hold    = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      MC_IDLE: begin
        if (!exc_req && start) begin
          if (cycles <= CNT_W'(1)) begin
            done = 1'b1;
          end else begin
            ex_hold    = 1'b1;
            cnt_next   = cycles - CNT_W'(2);
            state_next = MC_BUSY;
          end
        end
      end
      MC_BUSY: begin
        if (exc_req) begin
          abort      = 1'b1;
          cnt_next   = '0;
          state_next = MC_IDLE;
        end else if (cnt != '0) begin
          ex_hold  = 1'b1;
          cnt_next = cnt - CNT_W'(1);
        end else begin
          done       = 1'b1;
          state_next = stallreq_mem ? MC_HOLD : MC_IDLE;
        end
      end
      MC_HOLD: begin
        if (exc_req) begin
          abort      = 1'b1;
          cnt_next   = '0;
          state_next = MC_IDLE;
        end else begin
          done    = 1'b1;
          ex_hold = stallreq_mem;
          if (!stallreq_mem)
            state_next = MC_IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = MC_IDLE;
      end
    endcase
  end

  // State and counter registers; reset takes priority over any start.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign busy = (state != MC_IDLE);

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush controller for the 5-stage MIPS32 pipeline.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   pipe_ctrl_if.slave
//         in : stallreq_id, stallreq_mem, ex_mc_start, ex_mc_cycles,
//              exc_req, exc_pc
//         out: stall (bit0 PC .. bit5 WB), flush, new_pc, ex_mc_busy,
//              ex_mc_done, ex_mc_abort, perf_stall_cnt
// Priority: exception flush > MEM wait > EX hold > ID load-use.
// ---------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int PERF_W = PERF_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  logic              ex_hold;
  logic              mc_done;
  logic              mc_abort;
  logic              mc_busy;
  logic [5:0]        stall;
  logic [PERF_W-1:0] perf_cnt;

  pipe_ctrl_mc_seq #(
    .CNT_W (CNT_W)
  ) u_mc_seq (
    .clk          (clk),
    .rst          (rst),
    .start        (bus.ex_mc_start),
    .cycles       (bus.ex_mc_cycles),
    .exc_req      (bus.exc_req),
    .stallreq_mem (bus.stallreq_mem),
    .ex_hold      (ex_hold),
    .done         (mc_done),
    .abort        (mc_abort),
    .busy         (mc_busy)
  );

  // An exception flushes every stage instead of stalling, so the pipeline
  // must be free to load the handler address in the same cycle.
  always_comb begin
    stall = STALL_NONE;
    if (!bus.exc_req)
      stall = stall_select(bus.stallreq_mem, ex_hold, bus.stallreq_id);
  end

  // Counts every cycle in which any stage is held.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE)
      perf_cnt <= '0;
    else if (stall != STALL_NONE)
      perf_cnt <= perf_cnt + PERF_W'(1);
  end

  assign bus.stall          = stall;
  assign bus.flush          = bus.exc_req;
  assign bus.new_pc         = bus.exc_req ? bus.exc_pc : ZERO_WORD;
  assign bus.ex_mc_busy     = mc_busy;
  assign bus.ex_mc_done     = mc_done;
  assign bus.ex_mc_abort    = mc_abort;
  assign bus.perf_stall_cnt = perf_cnt;

endmodule
